// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: register map,
// CTRL/STATUS bit positions, pop FSM encoding and a STATUS packing helper.
package uart_rx_ctrl_pkg;

    // Register indices on the I/O bus
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TMO    = 2'd3;

    // CTRL bit positions
    localparam int CTRL_FSEL   = 0;
    localparam int CTRL_PACK   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLUSH  = 3;

    // STATUS bit positions (count occupies 3 bits starting at ST_COUNT)
    localparam int ST_VALID  = 0;
    localparam int ST_COUNT  = 1;
    localparam int ST_TFLAG  = 4;
    localparam int ST_RX_RDY = 5;

    // Pop FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_POP    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    // STATUS fields, MSB first so the packed layout matches the bit positions
    typedef struct packed {
        logic       rx_rdy;
        logic       tflag;
        logic [2:0] count;
        logic       valid;
    } status_t;

    // Zero-extend the STATUS fields to a bus word
    function automatic logic [31:0] status_word(input status_t st);
        return {26'd0, st};
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, the SoC I/O bus and
// the uart_rx FIFO. slave = controller side, master = bus/receiver side.
interface uart_rx_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_fsel;

    modport slave  (input  sel, we, addr, wdata, rx_rdy, rx_data,
                    output rdata, irq, rx_done, rx_fsel);
    modport master (output sel, we, addr, wdata, rx_rdy, rx_data,
                    input  rdata, irq, rx_done, rx_fsel);
endinterface

// File: rtl/uart_rx_ctrl_timer.sv
// Idle timer for partial words: counts while run is high and reports a hit
// when the count equals a non-zero limit. Only instantiated when
// UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl_timer
    import uart_rx_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 hit
);
    localparam logic [TIMEOUT_W-1:0] ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] timer_r;

    // A zero limit disables the timeout altogether
    assign hit = run && (limit != '0) && (timer_r == limit);

    // Count idle cycles; restart whenever the run condition drops or on a hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= '0;
        end else if (!run || hit) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + ONE;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: drains the uart_rx FIFO through rx_rdy/rx_done,
// packs bytes into 32-bit words (or delivers single bytes), exposes
// DATA/STATUS/CTRL/TMO registers and a level interrupt.
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (idle timeout, TMO, tflag).
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_RST = 16'd2000
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);
    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [31:0]          hold_r;
    logic [2:0]           count_r;
    logic                 valid_r;
    logic                 tflag_s;
    logic                 fsel_r;
    logic                 pack_r;
    logic                 irq_en_r;
    logic                 irq_r;
    logic                 rx_done_r;
    logic [TIMEOUT_W-1:0] tmo_s;
    logic                 tmo_hit_s;
    logic                 wr_s;
    logic                 ctrl_wr_s;
    logic                 rd_data_s;
    logic                 flush_s;
    logic                 pop_s;
    logic                 start_s;
    status_t              status_s;
    logic [31:0]          rdata_s;

    assign wr_s      = bus.sel & bus.we;
    assign ctrl_wr_s = wr_s & (bus.addr == REG_CTRL);
    assign rd_data_s = bus.sel & ~bus.we & (bus.addr == REG_DATA) & valid_r;
    assign flush_s   = ctrl_wr_s & bus.wdata[CTRL_FLUSH] & (count_r != 3'd0) & ~valid_r;
    assign pop_s     = (state_r == S_POP);
    // A completion landing this cycle sets valid on the same edge, so a new
    // pop must not start alongside it.
    assign start_s   = bus.rx_rdy & ~valid_r & ~flush_s & ~tmo_hit_s;

    // Pop sequencing: IDLE -> POP (strobe) -> SETTLE (receiver updates)
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    state_nxt_s = S_POP;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_POP:    state_nxt_s = S_SETTLE;
            S_SETTLE: state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state and the registered pop strobe (high exactly in S_POP)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            rx_done_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rx_done_r <= (state_nxt_s == S_POP);
        end
    end

    // Word assembly and completion; a DATA read hands the word over
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r  <= 32'd0;
            count_r <= 3'd0;
            valid_r <= 1'b0;
        end else if (rd_data_s) begin
            hold_r  <= 32'd0;
            count_r <= 3'd0;
            valid_r <= 1'b0;
        end else if (pop_s) begin
            hold_r[{count_r[1:0], 3'b000} +: 8] <= bus.rx_data;
            count_r <= count_r + 3'd1;
            valid_r <= ~pack_r | (count_r == 3'd3) | flush_s;
        end else if (flush_s || tmo_hit_s) begin
            valid_r <= 1'b1;
        end
    end

    // CTRL register; the flush bit is a strobe and is not stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsel_r   <= 1'b0;
            pack_r   <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            fsel_r   <= bus.wdata[CTRL_FSEL];
            pack_r   <= bus.wdata[CTRL_PACK];
            irq_en_r <= bus.wdata[CTRL_IRQ_EN];
        end
    end

    // Level interrupt, one cycle behind valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r & valid_r;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_r;
    logic                 tflag_r;
    logic                 tmo_run_s;

    assign tmo_run_s = pack_r & ~valid_r & (count_r != 3'd0) & (count_r <= 3'd3)
                     & (state_r == S_IDLE);
    assign tmo_s     = tmo_r;
    assign tflag_s   = tflag_r;

    uart_rx_ctrl_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (tmo_run_s),
        .limit (tmo_r),
        .hit   (tmo_hit_s)
    );

    // TMO limit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= TIMEOUT_RST;
        end else if (wr_s && (bus.addr == REG_TMO)) begin
            tmo_r <= bus.wdata[TIMEOUT_W-1:0];
        end
    end

    // Timeout flag: set by a timeout completion, cleared by read or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tflag_r <= 1'b0;
        end else if (rd_data_s || flush_s) begin
            tflag_r <= 1'b0;
        end else if (tmo_hit_s) begin
            tflag_r <= 1'b1;
        end
    end
`else
    assign tmo_s     = '0;
    assign tmo_hit_s = 1'b0;
    assign tflag_s   = 1'b0;
`endif

    assign status_s = '{rx_rdy: bus.rx_rdy, tflag: tflag_s, count: count_r, valid: valid_r};

    // Read mux: combinational from addr, zero when not selected
    always_comb begin
        rdata_s = 32'd0;
        if (bus.sel) begin
            case (bus.addr)
                REG_DATA:   rdata_s = valid_r ? hold_r : 32'd0;
                REG_STATUS: rdata_s = status_word(status_s);
                REG_CTRL:   rdata_s = {29'd0, irq_en_r, pack_r, fsel_r};
                REG_TMO:    rdata_s = {{(32-TIMEOUT_W){1'b0}}, tmo_s};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.rdata   = rdata_s;
    assign bus.irq     = irq_r;
    assign bus.rx_done = rx_done_r;
    assign bus.rx_fsel = fsel_r;

endmodule
